// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: multi-cycle instruction fetch stage.
//
// Takes one PC at a time from the PC unit and reads the instruction word over
// the AR/R channels of an AXI4-Lite master port. The word is held for decode
// until decode accepts it. A misaligned PC or a non-OKAY read response is
// passed to decode as a faulting instruction, so decode or the CSR logic takes
// the trap and fetch keeps running. flush_i abandons the fetch in progress.
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   pc_i, pc_valid_i, pc_ready_o  PC from the PC unit (valid/ready)
//   flush_i                       redirect from execute
//   araddr_o, arvalid_o, arready_i           AXI AR channel
//   rdata_i, rresp_i, rvalid_i, rready_o     AXI R channel
//   inst_o, inst_pc_o, fault_o, inst_valid_o, inst_ready_i   to decode
//   fetch_cnt_o                   number of instructions decode has accepted
module ifu_axi_fetch #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic [PC_W-1:0]   araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [INST_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              fault_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e state_q;
  // Set when a flush hits an AXI read already issued; the response must
  // still be accepted (one outstanding read) but is thrown away.
  logic   discard_q;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  assign pc_ready_o = (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      discard_q    <= 1'b0;
      araddr_o     <= '0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      fault_o      <= 1'b0;
      fetch_cnt_o  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pc_valid_i && !flush_i) begin
            araddr_o  <= pc_i;
            inst_pc_o <= pc_i;
            if (pc_i[1:0] != 2'b00) begin
              // Misaligned: no bus access, hand a faulting word straight to decode.
              inst_o       <= '0;
              fault_o      <= 1'b1;
              inst_valid_o <= 1'b1;
              state_q      <= StHold;
            end else begin
              arvalid_o <= 1'b1;
              state_q   <= StAddr;
            end
          end
        end

        StAddr: begin
          // AR must not be withdrawn once offered, so a flush only marks the
          // eventual response for discard.
          if (flush_i) begin
            discard_q <= 1'b1;
          end
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state_q   <= StData;
          end
        end

        StData: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            if (discard_q || flush_i) begin
              discard_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              inst_o       <= rdata_i;
              fault_o      <= (rresp_i != 2'b00);
              inst_valid_o <= 1'b1;
              state_q      <= StHold;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end

        StHold: begin
          // A flush overrides a simultaneous accept: the instruction is on the
          // wrong path and must not be counted as retired fetch.
          if (flush_i) begin
            inst_valid_o <= 1'b0;
            state_q      <= StIdle;
          end else if (inst_ready_i) begin
            fetch_cnt_o  <= fetch_cnt_o + CntOne;
            inst_valid_o <= 1'b0;
            state_q      <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Self-checking bench for ifu_axi_fetch: a table of complete fetches with
// programmable handshake delays, followed by hand-written flush and reset
// sequences.
module tb_ifu_axi_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        fault_o;
  logic [63:0] fetch_cnt_o;

  ifu_axi_fetch #(.PC_W(32), .INST_W(32), .CNT_W(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .araddr_o     (araddr_o),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .fault_o      (fault_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [63:0] cnt_exp = '0;

  typedef struct {
    logic [31:0] pc;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          rdy_dly;
    logic        exp_req;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_fetch(input vec_t v);
    chk("idle_pc_ready", 64'(pc_ready_o), 64'd1);
    pc_i       = v.pc;
    pc_valid_i = 1'b1;
    step();
    pc_valid_i = 1'b0;
    chk("pc_ready_busy", 64'(pc_ready_o), 64'd0);
    chk("arvalid_issue", 64'(arvalid_o), 64'(v.exp_req));
    if (v.exp_req) begin
      chk("araddr", 64'(araddr_o), 64'(v.pc));
      for (int i = 0; i < v.ar_dly; i++) begin
        step();
        chk("arvalid_hold", 64'(arvalid_o), 64'd1);
        chk("araddr_hold", 64'(araddr_o), 64'(v.pc));
        chk("pc_ready_ar_wait", 64'(pc_ready_o), 64'd0);
      end
      arready_i = 1'b1;
      step();
      arready_i = 1'b0;
      chk("arvalid_drop", 64'(arvalid_o), 64'd0);
      chk("rready_up", 64'(rready_o), 64'd1);
      for (int i = 0; i < v.r_dly; i++) begin
        step();
        chk("rready_hold", 64'(rready_o), 64'd1);
        chk("inst_valid_early", 64'(inst_valid_o), 64'd0);
      end
      rdata_i  = v.rdata;
      rresp_i  = v.rresp;
      rvalid_i = 1'b1;
      step();
      rvalid_i = 1'b0;
      rdata_i  = 32'h0;
      rresp_i  = 2'b00;
      chk("rready_drop", 64'(rready_o), 64'd0);
    end
    chk("inst_valid", 64'(inst_valid_o), 64'd1);
    chk("inst", 64'(inst_o), 64'(v.exp_inst));
    chk("inst_pc", 64'(inst_pc_o), 64'(v.pc));
    chk("fault", 64'(fault_o), 64'(v.exp_fault));
    for (int i = 0; i < v.rdy_dly; i++) begin
      step();
      chk("hold_valid", 64'(inst_valid_o), 64'd1);
      chk("hold_inst", 64'(inst_o), 64'(v.exp_inst));
      chk("hold_fault", 64'(fault_o), 64'(v.exp_fault));
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    cnt_exp++;
    chk("inst_valid_drop", 64'(inst_valid_o), 64'd0);
    chk("pc_ready_back", 64'(pc_ready_o), 64'd1);
    chk("fetch_cnt", fetch_cnt_o, cnt_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            pc            ar r  rdata         rresp rdy req exp_inst      fault
    vecs[0] = '{32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 0, 1'b1, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 5, 4, 32'h1234_5678, 2'b00, 3, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h8000_0002, 0, 0, 32'h0,         2'b00, 0, 1'b0, 32'h0,         1'b1};
    vecs[3] = '{32'h8000_0008, 0, 1, 32'hCAFE_BABE, 2'b10, 1, 1'b1, 32'hCAFE_BABE, 1'b1};
    vecs[4] = '{32'h8000_000C, 2, 0, 32'h0000_0013, 2'b11, 0, 1'b1, 32'h0000_0013, 1'b1};
    vecs[5] = '{32'h8000_0001, 0, 0, 32'h0,         2'b00, 2, 1'b0, 32'h0,         1'b1};

    rst_i = 1'b0; pc_i = '0; pc_valid_i = 0; flush_i = 0; arready_i = 0;
    rdata_i = '0; rresp_i = '0; rvalid_i = 0; inst_ready_i = 0;
    #23;
    chk("rst_arvalid", 64'(arvalid_o), 64'd0);
    chk("rst_rready", 64'(rready_o), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_fault", 64'(fault_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("rst_araddr", 64'(araddr_o), 64'd0);
    chk("rst_cnt", fetch_cnt_o, 64'd0);
    chk("rst_pc_ready", 64'(pc_ready_o), 64'd1);
    rst_i = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_fetch(vecs[i]);

    // Flush in IDLE blocks acceptance.
    pc_i = 32'h8000_0040; pc_valid_i = 1; flush_i = 1;
    step();
    pc_valid_i = 0; flush_i = 0;
    chk("idle_flush_pc_ready", 64'(pc_ready_o), 64'd1);
    chk("idle_flush_arvalid", 64'(arvalid_o), 64'd0);

    // Flush in ADDR: AR stays up until arready, response consumed and dropped.
    pc_i = 32'h8000_0020; pc_valid_i = 1;
    step();
    pc_valid_i = 0;
    flush_i = 1;
    step();
    flush_i = 0;
    chk("addr_flush_arvalid", 64'(arvalid_o), 64'd1);
    chk("addr_flush_araddr", 64'(araddr_o), 64'h8000_0020);
    step();
    chk("addr_flush_arvalid2", 64'(arvalid_o), 64'd1);
    arready_i = 1;
    step();
    arready_i = 0;
    chk("addr_flush_rready", 64'(rready_o), 64'd1);
    rdata_i = 32'hDEAD_BEEF; rvalid_i = 1;
    step();
    rvalid_i = 0;
    chk("addr_flush_rready_drop", 64'(rready_o), 64'd0);
    chk("addr_flush_no_valid", 64'(inst_valid_o), 64'd0);
    chk("addr_flush_idle", 64'(pc_ready_o), 64'd1);
    step();
    chk("addr_flush_no_valid2", 64'(inst_valid_o), 64'd0);
    chk("addr_flush_cnt", fetch_cnt_o, cnt_exp);

    // Flush coinciding with rvalid in DATA, then a normal fetch.
    pc_i = 32'h8000_0030; pc_valid_i = 1;
    step();
    pc_valid_i = 0; arready_i = 1;
    step();
    arready_i = 0;
    rdata_i = 32'hBADB_AD00; rvalid_i = 1; flush_i = 1;
    step();
    rvalid_i = 0; flush_i = 0;
    chk("data_flush_no_valid", 64'(inst_valid_o), 64'd0);
    chk("data_flush_idle", 64'(pc_ready_o), 64'd1);
    v = '{32'h8000_0010, 0, 0, 32'h0000_0517, 2'b00, 0, 1'b1, 32'h0000_0517, 1'b0};
    run_fetch(v);

    // Flush in HOLD with a simultaneous accept: not counted.
    pc_i = 32'h8000_0042; pc_valid_i = 1;
    step();
    pc_valid_i = 0;
    chk("hold_flush_pre_valid", 64'(inst_valid_o), 64'd1);
    flush_i = 1; inst_ready_i = 1;
    step();
    flush_i = 0; inst_ready_i = 0;
    chk("hold_flush_valid", 64'(inst_valid_o), 64'd0);
    chk("hold_flush_cnt", fetch_cnt_o, cnt_exp);
    chk("hold_flush_idle", 64'(pc_ready_o), 64'd1);

    // Asynchronous reset while waiting in DATA.
    pc_i = 32'h8000_0050; pc_valid_i = 1;
    step();
    pc_valid_i = 0; arready_i = 1;
    step();
    arready_i = 0;
    chk("pre_rst_rready", 64'(rready_o), 64'd1);
    #2 rst_i = 0;
    #1;
    cnt_exp = '0;
    chk("arst_rready", 64'(rready_o), 64'd0);
    chk("arst_araddr", 64'(araddr_o), 64'd0);
    chk("arst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("arst_cnt", fetch_cnt_o, 64'd0);
    chk("arst_pc_ready", 64'(pc_ready_o), 64'd1);
    #10 rst_i = 1;
    rdata_i = 32'h1111_1111; rvalid_i = 1;
    step();
    rvalid_i = 0;
    chk("post_rst_pc_ready", 64'(pc_ready_o), 64'd1);
    chk("post_rst_no_valid", 64'(inst_valid_o), 64'd0);
    chk("post_rst_arvalid", 64'(arvalid_o), 64'd0);
    v = '{32'h8000_0060, 1, 1, 32'h0040_0113, 2'b00, 1, 1'b1, 32'h0040_0113, 1'b0};
    run_fetch(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
